status_color_seq: RTL

Status-colour sequencer that drives the 24-bit GRB colour input of the `ws2812b` controller, which sits directly downstream. It watches the ESP32 SPI-flash chip select and tracks three status phases: idle, active programming, and completed. In idle and completed it produces a "breathing" (triangle-wave brightness) colour; during active programming it produces a solid colour. It replaces the static colour mux in `top` and emits a one-cycle strobe whenever the colour changes.

---
 rtl/status_color_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/status_color_seq.sv
// Status-colour sequencer for the ws2812b GRB input: breathing colour in idle/done,
// solid colour while the ESP32 holds its SPI-flash chip select low.
module status_color_seq #(
    parameter int          CLOCK_MHZ    = 27,
    parameter int          STEP_US      = 4000,
    parameter int          HOLD_MS      = 250,
    parameter logic [23:0] IDLE_COLOR   = 24'h001010,
    parameter logic [23:0] ACTIVE_COLOR = 24'h100010,
    parameter logic [23:0] DONE_COLOR   = 24'h100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        esp_cs_n,
    output logic [23:0] color_out,
    output logic        color_update
);

    localparam int STEP_CYCLES = CLOCK_MHZ * STEP_US;
    localparam int HOLD_CYCLES = CLOCK_MHZ * 1000 * HOLD_MS;
    localparam int STEP_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // 16-bit product, keep the upper byte: 0x10 at level 255 yields 0x0F
    function automatic logic [7:0] scale_chan(input logic [7:0] chan, input logic [7:0] lvl);
        logic [15:0] prod;
        prod = {8'd0, chan} * {8'd0, lvl};
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_grb(input logic [23:0] grb, input logic [7:0] lvl);
        return {scale_chan(grb[23:16], lvl), scale_chan(grb[15:8], lvl), scale_chan(grb[7:0], lvl)};
    endfunction

    logic              cs_sync1_r;
    logic              cs_sync2_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic [7:0]        level_r;
    logic              dir_down_r;
    state_t            state_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    logic              cs_low_s;
    logic              step_tick_s;
    logic [STEP_W-1:0] step_cnt_nxt_s;
    logic [7:0]        level_nxt_s;
    logic              dir_down_nxt_s;
    state_t            state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic [23:0]       color_nxt_s;

    assign cs_low_s    = ~cs_sync2_r;
    assign step_tick_s = (step_cnt_r == STEP_LAST);

    // Prescaler and triangle-wave brightness level
    always_comb begin
        step_cnt_nxt_s = step_cnt_r + STEP_W'(1);
        level_nxt_s    = level_r;
        dir_down_nxt_s = dir_down_r;
        if (step_tick_s) begin
            step_cnt_nxt_s = {STEP_W{1'b0}};
            if (dir_down_r) begin
                level_nxt_s    = level_r - 8'd1;
                dir_down_nxt_s = (level_r != 8'd1);
            end else begin
                level_nxt_s    = level_r + 8'd1;
                dir_down_nxt_s = (level_r == 8'd254);
            end
        end else begin
            level_nxt_s    = level_r;
            dir_down_nxt_s = dir_down_r;
        end
    end

    // Status phase, hold timer and the colour that follows the next state
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        color_nxt_s    = 24'h000000;
        // Reloading in any state means a short CS pulse seen in IDLE/DONE still gets a full hold
        if (cs_low_s) begin
            hold_cnt_nxt_s = HOLD_LOAD;
        end else if ((state_r == ST_ACTIVE) && (hold_cnt_r != {HOLD_W{1'b0}})) begin
            hold_cnt_nxt_s = hold_cnt_r - HOLD_W'(1);
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
        case (state_r)
            ST_IDLE:   state_nxt_s = cs_low_s ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_nxt_s = (!cs_low_s && (hold_cnt_r == {HOLD_W{1'b0}})) ? ST_DONE : ST_ACTIVE;
            ST_DONE:   state_nxt_s = cs_low_s ? ST_ACTIVE : ST_DONE;
            default:   state_nxt_s = ST_IDLE;
        endcase
        case (state_nxt_s)
            ST_IDLE:   color_nxt_s = scale_grb(IDLE_COLOR, level_nxt_s);
            ST_ACTIVE: color_nxt_s = ACTIVE_COLOR;
            ST_DONE:   color_nxt_s = scale_grb(DONE_COLOR, level_nxt_s);
            default:   color_nxt_s = 24'h000000;
        endcase
    end

    // All state and the registered colour/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync1_r   <= 1'b1;
            cs_sync2_r   <= 1'b1;
            step_cnt_r   <= {STEP_W{1'b0}};
            level_r      <= 8'd0;
            dir_down_r   <= 1'b0;
            state_r      <= ST_IDLE;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            color_out    <= 24'h000000;
            color_update <= 1'b0;
        end else begin
            cs_sync1_r   <= esp_cs_n;
            cs_sync2_r   <= cs_sync1_r;
            step_cnt_r   <= step_cnt_nxt_s;
            level_r      <= level_nxt_s;
            dir_down_r   <= dir_down_nxt_s;
            state_r      <= state_nxt_s;
            hold_cnt_r   <= hold_cnt_nxt_s;
            color_out    <= color_nxt_s;
            color_update <= (color_nxt_s != color_out);
        end
    end

endmodule
